// File: rtl/fsmc_master_if.sv
// FSMC master interface bundle: request/response handshake plus the split parallel bus.
//   req_valid/req_ready/req_op/req_data : single-word request channel
//   rsp_valid/rsp_data                  : read response (one-cycle pulse, data held)
//   busy                                : master not idle
//   nce/noe/nwe/ale/cle                 : bus strobes
//   data_o/data_oe/data_i               : split data pins (tristate built outside)
interface fsmc_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        busy;
  logic        nce;
  logic        noe;
  logic        nwe;
  logic        ale;
  logic        cle;
  logic [15:0] data_o;
  logic        data_oe;
  logic [15:0] data_i;

  modport master (
    input  req_valid, req_op, req_data, data_i,
    output req_ready, rsp_valid, rsp_data, busy,
    output nce, noe, nwe, ale, cle, data_o, data_oe
  );

  modport slave (
    output req_valid, req_op, req_data, data_i,
    input  req_ready, rsp_valid, rsp_data, busy,
    input  nce, noe, nwe, ale, cle, data_o, data_oe
  );
endinterface

// File: rtl/fsmc_master.sv
// FSMC-style bus initiator. Accepts one request at a time and runs it through
// SETUP -> STROBE -> HOLD (-> TURN for reads) with programmable cycle counts.
//   clk     : clock
//   reset_l : asynchronous active-low reset
//   bus     : fsmc_master_if.master (request/response channel and bus pins)
module fsmc_master #(
  parameter int unsigned SETUP  = 2,
  parameter int unsigned STROBE = 4,
  parameter int unsigned HOLD   = 2,
  parameter int unsigned TURN   = 2
) (
  input  logic          clk,
  input  logic          reset_l,
  fsmc_master_if.master bus
);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StTurn} state_e;

  localparam logic [1:0] OpWrite = 2'b00;
  localparam logic [1:0] OpAddr  = 2'b01;
  localparam logic [1:0] OpRead  = 2'b10;
  localparam logic [1:0] OpCmd   = 2'b11;

  // Counter reload values: a state lasting N cycles loads N-1 on entry.
  localparam logic [3:0] SetupLd  = 4'(SETUP - 1);
  localparam logic [3:0] StrobeLd = 4'(STROBE - 1);
  localparam logic [3:0] HoldLd   = 4'(HOLD - 1);
  localparam logic [3:0] TurnLd   = 4'(TURN - 1);

  state_e      r_state, w_state_d;
  logic [3:0]  r_cnt, w_cnt_d;
  logic [1:0]  r_op;
  logic [15:0] r_data;
  logic        w_accept;
  logic        w_cnt_zero;

  logic        r_req_ready, r_rsp_valid, r_nce, r_noe, r_nwe, r_ale, r_cle, r_data_oe;
  logic [15:0] r_rsp_data, r_data_o;
  logic        w_req_ready_d, w_rsp_valid_d, w_nce_d, w_noe_d, w_nwe_d, w_ale_d, w_cle_d;
  logic        w_data_oe_d, w_rsp_capture, w_active, w_write;
  logic [1:0]  w_op_nxt;
  logic [15:0] w_data_nxt, w_data_o_d;

  assign w_cnt_zero = (r_cnt == 4'd0);

  // State register, counter, request latch and registered outputs
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state     <= StIdle;
      r_cnt       <= 4'd0;
      r_op        <= OpWrite;
      r_data      <= 16'h0000;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 16'h0000;
      r_nce       <= 1'b1;
      r_noe       <= 1'b1;
      r_nwe       <= 1'b1;
      r_ale       <= 1'b0;
      r_cle       <= 1'b0;
      r_data_o    <= 16'h0000;
      r_data_oe   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_op        <= w_op_nxt;
      r_data      <= w_data_nxt;
      r_req_ready <= w_req_ready_d;
      r_rsp_valid <= w_rsp_valid_d;
      if (w_rsp_capture) r_rsp_data <= bus.data_i;
      r_nce       <= w_nce_d;
      r_noe       <= w_noe_d;
      r_nwe       <= w_nwe_d;
      r_ale       <= w_ale_d;
      r_cle       <= w_cle_d;
      r_data_o    <= w_data_o_d;
      r_data_oe   <= w_data_oe_d;
    end
  end

  // Next-state and counter
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_accept  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.req_valid && r_req_ready) begin
          w_accept  = 1'b1;
          w_state_d = StSetup;
          w_cnt_d   = SetupLd;
        end
      end
      StSetup: begin
        if (w_cnt_zero) begin
          w_state_d = StStrobe;
          w_cnt_d   = StrobeLd;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      StStrobe: begin
        if (w_cnt_zero) begin
          w_state_d = StHold;
          w_cnt_d   = HoldLd;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      StHold: begin
        if (w_cnt_zero) begin
          if ((r_op == OpRead) && (TURN > 0)) begin
            w_state_d = StTurn;
            w_cnt_d   = TurnLd;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      StTurn: begin
        if (w_cnt_zero) w_state_d = StIdle;
        else            w_cnt_d   = r_cnt - 4'd1;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Output next values are decoded from the next state so the registered pins
  // change on the same edge the state does. On the accept edge the request
  // latch is not yet loaded, so the incoming op/data are used directly.
  always_comb begin
    w_op_nxt      = w_accept ? bus.req_op   : r_op;
    w_data_nxt    = w_accept ? bus.req_data : r_data;
    w_active      = (w_state_d == StSetup) || (w_state_d == StStrobe) || (w_state_d == StHold);
    w_write       = (w_op_nxt != OpRead);
    w_nce_d       = !w_active;
    w_nwe_d       = !((w_state_d == StStrobe) && w_write);
    w_noe_d       = !((w_state_d == StStrobe) && !w_write);
    w_ale_d       = w_active && (w_op_nxt == OpAddr);
    w_cle_d       = w_active && (w_op_nxt == OpCmd);
    w_data_oe_d   = w_active && w_write;
    w_data_o_d    = w_active ? w_data_nxt : r_data_o;
    w_req_ready_d = (w_state_d == StIdle);
    // Last STROBE cycle of a read: sample the bus and flag the response.
    w_rsp_capture = (r_state == StStrobe) && w_cnt_zero && (r_op == OpRead);
    w_rsp_valid_d = w_rsp_capture;
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.busy      = (r_state != StIdle);
  assign bus.nce       = r_nce;
  assign bus.noe       = r_noe;
  assign bus.nwe       = r_nwe;
  assign bus.ale       = r_ale;
  assign bus.cle       = r_cle;
  assign bus.data_o    = r_data_o;
  assign bus.data_oe   = r_data_oe;

  always_ff @(posedge clk) begin
    assert ((SETUP >= 1) && (SETUP <= 15) && (STROBE >= 1) && (STROBE <= 15) &&
            (HOLD >= 1) && (HOLD <= 15) && (TURN <= 15))
      else $error("fsmc_master: timing parameter out of range");
    assert (r_noe || r_nwe) else $error("fsmc_master: noe and nwe low together");
    assert (!(r_data_oe && !r_noe)) else $error("fsmc_master: data_oe while noe low");
    assert (!(r_ale && r_cle)) else $error("fsmc_master: ale and cle high together");
  end

endmodule

// File: doc/fsmc_master.md
# fsmc_master

FPGA-side initiator for the FSMC-style parallel bus that the team's FSMC slave blocks respond to. It accepts single-word requests on a valid/ready interface and drives the bus strobes nce, noe, nwe, ale and cle with programmable setup, strobe, hold and turnaround timing. Supported requests are data write, address (ALE) write, command (CLE) write and data read. The data pins are split into out, output-enable and in; the enclosing top level builds the 16-bit tristate.

## Interface
- SETUP, default 2: cycles nce, ale/cle and write data are valid before the strobe falls (1..15).
- STROBE, default 4: cycles nwe or noe is held low (1..15).
- HOLD, default 2: cycles after the strobe rises during which nce, ale/cle and write data are held (1..15).
- TURN, default 2: extra idle cycles after a read, with nce high and data_oe low (0..15).
- clk  in  1  single clock for all logic.
- reset_l  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid and req_ready are both high at a clk edge.
- req_op  in  2  request type: 00 data write, 01 address write (ale=1), 10 read, 11 command write (cle=1).
- req_data  in  16  write/address/command word; ignored for reads.
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid.
- rsp_data  out  16  read data; holds its value until the next read.
- busy  out  1  high whenever the block is not in IDLE.
- nce, noe, nwe  out  1 each  active-low chip enable, output enable and write enable.
- ale, cle  out  1 each  address and command latch enables.
- data_o  out  16  bus write data.
- data_oe  out  1  drives data_o onto the pins.
- data_i  in  16  bus read data.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, TURN. A single 4-bit down-counter times every state. All bus outputs are registered.
- IDLE:
  - req_ready=1, nce=1, noe=nwe=1, ale=cle=0, data_oe=0.
  - On accept, latch req_op and req_data and go to SETUP.
- SETUP:
  - nce=0.
  - op 01 sets ale=1; op 11 sets cle=1.
  - For write ops (00/01/11): data_o=req_data and data_oe=1.
  - For read ops: data_oe=0.
  - Lasts SETUP cycles, then go to STROBE.
- STROBE:
  - nwe=0 for write ops; noe=0 for reads. All other signals are as in SETUP.
  - Lasts STROBE cycles.
  - For reads, data_i is registered into rsp_data at the edge that ends the last STROBE cycle.
- HOLD:
  - The strobe returns high. nce, ale/cle, data_o and data_oe are unchanged.
  - rsp_valid=1 during the first HOLD cycle of a read only.
  - Lasts HOLD cycles. Then go to TURN for reads with TURN>0; otherwise go to IDLE.
- TURN:
  - Lasts TURN cycles with all bus signals in their IDLE values and req_ready=0. Then go to IDLE.
- Never asserted: noe and nwe low together; data_oe=1 while noe=0; ale and cle high together.
- nce returns high for at least one cycle (IDLE) between any two transactions.
- Out-of-range parameters: behaviour is undefined. An assertion fires in simulation.

## Timing
- Reset values (asserted asynchronously, independent of clk):
  - nce=noe=nwe=1.
  - ale=cle=0.
  - data_oe=0, data_o=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, busy=0.
  - State = IDLE.
- req_ready rises on the first clk edge after reset_l deasserts.
- Let E0 be the accept edge:
  - nce falls at E0.
  - The strobe falls at E0+SETUP and rises at E0+SETUP+STROBE.
  - nce rises at E0+SETUP+STROBE+HOLD.
- Read latency: rsp_valid is high in the cycle after E0+SETUP+STROBE (defaults: E0+6..E0+7).
- Minimum accept-to-accept spacing:
  - Writes: SETUP+STROBE+HOLD+1 cycles (9 with defaults).
  - Reads: that plus TURN (11 with defaults).
- req_valid deasserting while not in IDLE has no effect; a latched request always completes.
- reset_l low mid-transaction aborts immediately to reset values. No rsp_valid is generated and the request is lost.
- Default STROBE=4 covers a same-clock responder with a 2-edge strobe synchronizer plus one registered memory read.

## Test plan
- After reset, single data write 0xBEEF with defaults:
  - nce low for cycles E0..E0+7 and nwe low for E0+2..E0+5.
  - data_o=0xBEEF with data_oe=1 throughout; ale=cle=0.
  - req_ready high again at E0+8.
- Address write 0x0123, then data writes 0x1111 and 0x2222 back-to-back (req_valid held high):
  - ale=1 only during the first transaction.
  - Accepts occur 9 cycles apart.
  - The FSMC slave model stores 0x1111 at address 0x123 and 0x2222 at 0x124.
- Read with the bus model returning 0xA5C3 on data_i while noe is low:
  - rsp_valid pulses once at E0+6 with rsp_data=0xA5C3.
  - data_oe stays 0 from E0 to E0+10.
  - Next accept no earlier than E0+11.
- Read immediately followed by a write:
  - data_oe does not rise until 2 TURN cycles after nce goes high.
  - noe and nwe are never low together.
- Command write (op 11, 0x00FF): cle=1, ale=0 for the whole transaction; the slave model's address and memory are unchanged.
- reset_l pulsed low during the STROBE phase of a read:
  - noe and nce go high asynchronously within the same cycle.
  - No rsp_valid is produced.
  - req_ready returns one edge after release, and a following write completes normally.
